// File: rtl/wb_pkg.sv
// Shared types and constants for the integer register writeback stage.
// Load funct3 codes, register-file geometry and the queued-write entry.
package wb_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    // Unknown funct3 codes fall back to a full-word write.
    function automatic logic [XLEN-1:0] extract_load(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   res = {{24{b[7]}}, b};
            F3_LH:   res = {{16{h[15]}}, h};
            F3_LBU:  res = {24'd0, b};
            F3_LHU:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_alu_fifo.sv
// In-order FIFO of ALU results awaiting a free register-file write slot.
// Exposes its occupancy and a one-hot OR of the destination registers it holds.
module wb_alu_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  wb_entry_t                 push_dat_i,
    input  logic                      pop_i,
    output wb_entry_t                 head_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [XLEN-1:0]           rd_mask_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   scan_idx;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    assign count_d = count_q + {{(CW-1){1'b0}}, push_i} - {{(CW-1){1'b0}}, pop_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    always_comb begin
        rd_mask_o = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q) rd_mask_o[mem_q[scan_idx].rd] = 1'b1;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/reg_writeback.sv
// Sole writer of the register file: loads win, then queued ALU results, then ALU bypass.
// One-cycle registered write; ALU path stalls only on a full FIFO, loads never stall.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 ld_valid,
    input  logic [REG_IDX_W-1:0] ld_rd,
    input  logic [2:0]           ld_funct3,
    input  logic [1:0]           ld_off,
    input  logic [XLEN-1:0]      ld_rdata,
    output logic                 w_en,
    output logic [REG_IDX_W-1:0] rd,
    output logic [XLEN-1:0]      rdv,
    output logic [XLEN-1:0]      pending
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]   fifo_count;
    wb_entry_t       fifo_head, fifo_in, out_d;
    logic            push, pop, bypass, ld_take, alu_take, fifo_empty;
    logic [XLEN-1:0] fifo_mask, stage_mask;
    logic            w_en_q, w_en_d;
    wb_entry_t       out_q;

    // Ready looks only at registered occupancy, so a full FIFO refuses even while popping.
    assign alu_ready  = fifo_count < CW'(FIFO_DEPTH);
    assign ld_take    = ld_valid && (ld_rd != '0);
    assign alu_take   = alu_valid && alu_ready && (alu_rd != '0);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_in    = '{rd: alu_rd, data: alu_data};

    always_comb begin
        w_en_d = 1'b0;
        out_d  = '0;
        pop    = 1'b0;
        bypass = 1'b0;
        if (ld_take) begin
            w_en_d = 1'b1;
            out_d  = '{rd: ld_rd, data: extract_load(ld_funct3, ld_off, ld_rdata)};
        end else if (!fifo_empty) begin
            w_en_d = 1'b1;
            out_d  = fifo_head;
            pop    = 1'b1;
        end else if (alu_take) begin
            w_en_d = 1'b1;
            out_d  = fifo_in;
            bypass = 1'b1;
        end
    end

    assign push = alu_take && !bypass;

    wb_alu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (fifo_in),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count),
        .rd_mask_o  (fifo_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en_q <= 1'b0;
            out_q  <= '0;
        end else begin
            w_en_q <= w_en_d;
            out_q  <= out_d;
        end
    end

    assign w_en       = w_en_q;
    assign rd         = out_q.rd;
    assign rdv        = out_q.data;
    assign stage_mask = w_en_q ? (XLEN'(1) << out_q.rd) : '0;
    assign pending    = (fifo_mask | stage_mask) & ~XLEN'(1);

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized and directed bench for reg_writeback with a queue-based reference model.
// The driver predicts each cycle's write into a scoreboard; a monitor pops and compares.
module tb_reg_writeback;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, ld_valid = 1'b0;
    logic        alu_ready, w_en;
    logic [4:0]  alu_rd = '0, ld_rd = '0, rd;
    logic [31:0] alu_data = '0, ld_rdata = '0, rdv, pending;
    logic [2:0]  ld_funct3 = '0;
    logic [1:0]  ld_off = '0;

    reg_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_off(ld_off),
        .ld_rdata(ld_rdata), .w_en(w_en), .rd(rd), .rdv(rdv), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  mq_rd[$];
    logic [31:0] mq_data[$];
    bit          last_we = 1'b0;
    logic [4:0]  last_rd = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) % 256;
        h = (w >> (16 * off[1])) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] m;
        m = '0;
        foreach (mq_rd[i]) m[mq_rd[i]] = 1'b1;
        if (last_we) m[last_rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // One cycle of stimulus; the model decides what the next edge must write.
    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                        input bit lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] off, input logic [31:0] lw, output bit acc);
        bit   ready, byp;
        exp_t e;
        @(posedge clk);
        #2;
        ready = (mq_rd.size() < DEPTH);
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, ready});
        chk("pending", pending, model_pending());
        alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_valid = lv; ld_rd = lrd; ld_funct3 = f3; ld_off = off; ld_rdata = lw;
        acc = av && ready;
        byp = 1'b0;
        e   = '{we: 1'b0, rd: '0, data: '0};
        if (lv && lrd != 0) begin
            e = '{we: 1'b1, rd: lrd, data: ref_load(f3, off, lw)};
        end else if (mq_rd.size() > 0) begin
            e = '{we: 1'b1, rd: mq_rd.pop_front(), data: mq_data.pop_front()};
        end else if (acc && ard != 0) begin
            e   = '{we: 1'b1, rd: ard, data: adat};
            byp = 1'b1;
        end
        if (acc && ard != 0 && !byp) begin
            mq_rd.push_back(ard);
            mq_data.push_back(adat);
        end
        last_we = e.we;
        last_rd = e.rd;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        alu_valid = 1'b0; ld_valid = 1'b0;
        mq_rd.delete(); mq_data.delete(); exp_q.delete();
        last_we = 1'b0; last_rd = '0;
        #1;
        chk("rst_w_en", {31'd0, w_en}, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            chk("rst_hold_ready", {31'd0, alu_ready}, 32'd1);
        end
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{we: 1'b0, rd: '0, data: '0};
            chk("w_en", {31'd0, w_en}, {31'd0, e.we});
            if (e.we) begin
                chk("rd", {27'd0, rd}, {27'd0, e.rd});
                chk("rdv", rdv, e.data);
            end
        end
    end

    initial begin : driver
        bit acc;
        int k;
        logic [4:0] seq_rd [3];
        seq_rd[0] = 5'd1; seq_rd[1] = 5'd2; seq_rd[2] = 5'd3;

        do_reset(2);
        step(1, 5, 32'h1234, 0, 0, 0, 0, 0, acc);
        idle(2);

        step(0, 0, 0, 1, 7, 3'b000, 2'd2, 32'h80F0_7F01, acc);
        step(0, 0, 0, 1, 7, 3'b100, 2'd3, 32'h80F0_7F01, acc);
        step(0, 0, 0, 1, 7, 3'b001, 2'd0, 32'h80F0_7F01, acc);
        step(0, 0, 0, 1, 7, 3'b101, 2'd2, 32'h80F0_7F01, acc);
        idle(2);

        step(1, 3, 32'hAA, 1, 9, 3'b010, 2'd0, 32'hDEAD_BEEF, acc);
        idle(3);

        k = 0;
        for (int c = 0; c < 12; c++) begin
            step(k < 3, (k < 3) ? seq_rd[k] : 5'd0, 32'h100 + k, c < 5, 5'd20,
                 3'b010, 2'd0, 32'h5000 + c, acc);
            if (acc && k < 3) k++;
        end
        idle(3);

        step(1, 0, 32'hFFFF, 1, 0, 3'b010, 0, 32'h1111, acc);
        idle(2);

        step(1, 4, 32'h44, 1, 8, 3'b010, 0, 32'h88, acc);
        step(1, 6, 32'h66, 1, 9, 3'b010, 0, 32'h99, acc);
        do_reset(1);
        idle(3);

        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 2) != 0,
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 $urandom,
                 $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, acc);
        end
        idle(6);
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
